uart_receiver: RTL and testbench

//  UART receive path: recovers 5..9-bit frames from asynchronous serial line RX_Serial_In using 16x oversampling.

---
 rtl/uart_receiver.sv | 141 ++++++++++++++
 tb/tb_uart_receiver.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 16x oversampled UART receiver with 2-of-3 majority vote and valid/ready delivery
`timescale 1ns/1ps
module uart_receiver #(
   parameter int DATA_BITS   = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 Clk_In,
   input  logic                 Reset_In,
   input  logic                 Sample_Tick_In,
   input  logic                 RX_Serial_In,
   input  logic [1:0]           Parity_Mode_In,
   input  logic                 Data_Ready_In,
   output logic [DATA_BITS-1:0] Data_Out,
   output logic                 Data_Valid_Out,
   output logic                 Parity_Error_Out,
   output logic                 Framing_Error_Out,
   output logic                 Overrun_Error_Out,
   output logic                 RX_Busy_Out
);

   localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                 state_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [3:0]             cnt_q;
   logic [IDX_W-1:0]       idx_q;
   logic [DATA_BITS-1:0]   shift_q;
   logic [DATA_BITS-1:0]   data_q;
   logic [1:0]             mode_q;
   logic                   s7_q, s8_q;
   logic                   seen_high_q;
   logic                   par_err_q;
   logic                   valid_q, pe_q, fe_q, ovr_q;

   logic line, maj, mid, last, par_en, par_odd, deliver;

   assign line    = sync_q[SYNC_STAGES-1];
   assign maj     = (s7_q & s8_q) | (s7_q & line) | (s8_q & line);
   assign mid     = (cnt_q == 4'd9);
   assign last    = (cnt_q == 4'd15);
   assign par_en  = (mode_q == 2'b01) || (mode_q == 2'b10);
   assign par_odd = (mode_q == 2'b10);
   assign deliver = Sample_Tick_In && (state_q == STOP) && mid;

   always_ff @(posedge Clk_In or posedge Reset_In) begin
      if (Reset_In) begin
         state_q     <= IDLE;
         sync_q      <= '1;
         cnt_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         mode_q      <= '0;
         s7_q        <= 1'b0;
         s8_q        <= 1'b0;
         seen_high_q <= 1'b1;
         par_err_q   <= 1'b0;
         valid_q     <= 1'b0;
         pe_q        <= 1'b0;
         fe_q        <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], RX_Serial_In};
         ovr_q  <= 1'b0;

         if (valid_q && Data_Ready_In) begin
            valid_q <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
         end

         // A same-cycle accept frees the holding register, so the new frame wins over overrun
         if (deliver) begin
            if (!valid_q || Data_Ready_In) begin
               data_q  <= shift_q;
               pe_q    <= par_err_q;
               fe_q    <= !maj;
               valid_q <= 1'b1;
            end else begin
               ovr_q <= 1'b1;
            end
         end

         if (Sample_Tick_In) begin
            if (line) seen_high_q <= 1'b1;
            if (cnt_q == 4'd7) s7_q <= line;
            if (cnt_q == 4'd8) s8_q <= line;
            cnt_q <= cnt_q + 4'd1;

            case (state_q)
               IDLE: begin
                  cnt_q <= '0;
                  if (!line && seen_high_q) begin
                     state_q   <= START;
                     mode_q    <= Parity_Mode_In;
                     par_err_q <= 1'b0;
                  end
               end
               START: begin
                  if (mid && maj) begin
                     state_q <= IDLE;
                  end else if (last) begin
                     state_q <= DATA;
                     idx_q   <= '0;
                  end
               end
               DATA: begin
                  if (mid) shift_q <= {maj, shift_q[DATA_BITS-1:1]};
                  if (last) begin
                     if (idx_q == LAST_IDX) state_q <= par_en ? PARITY : STOP;
                     else                   idx_q   <= idx_q + 1'b1;
                  end
               end
               PARITY: begin
                  if (mid)  par_err_q <= ((^shift_q) ^ maj) != par_odd;
                  if (last) state_q   <= STOP;
               end
               STOP: begin
                  // Leave mid stop bit; a low stop bit also blocks restart until the line idles high
                  if (mid) begin
                     state_q <= IDLE;
                     if (!maj) seen_high_q <= 1'b0;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign Data_Out          = data_q;
   assign Data_Valid_Out    = valid_q;
   assign Parity_Error_Out  = pe_q;
   assign Framing_Error_Out = fe_q;
   assign Overrun_Error_Out = ovr_q;
   assign RX_Busy_Out       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed-vector bench for uart_receiver
`timescale 1ns/1ps
module tb_uart_receiver;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick = 1'b0;
   logic       rx = 1'b1;
   logic [1:0] pmode = 2'b00;
   logic       ready = 1'b1;
   logic [7:0] dout;
   logic       valid, perr, ferr, ovr, busy;

   int vectors = 0;
   int miscompares = 0;

   int         got_n = 0;
   logic [7:0] got_data = '0;
   logic       got_pe = 1'b0;
   logic       got_fe = 1'b0;
   int         valid_cyc = 0;
   int         ovr_cyc = 0;
   bit         busy_seen = 1'b0;

   uart_receiver #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
      .Clk_In            (clk),
      .Reset_In          (rst),
      .Sample_Tick_In    (tick),
      .RX_Serial_In      (rx),
      .Parity_Mode_In    (pmode),
      .Data_Ready_In     (ready),
      .Data_Out          (dout),
      .Data_Valid_Out    (valid),
      .Parity_Error_Out  (perr),
      .Framing_Error_Out (ferr),
      .Overrun_Error_Out (ovr),
      .RX_Busy_Out       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         repeat (3) @(negedge clk);
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (valid && ready) begin
         got_n    = got_n + 1;
         got_data = dout;
         got_pe   = perr;
         got_fe   = ferr;
      end
      if (valid) valid_cyc = valid_cyc + 1;
      if (ovr)   ovr_cyc   = ovr_cyc + 1;
      if (busy)  busy_seen = 1'b1;
   end

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      vectors = vectors + 1;
      if (got !== exp) begin
         miscompares = miscompares + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) begin
         do @(posedge clk); while (!tick);
      end
   endtask

   task automatic put_bit(input logic b);
      @(negedge clk);
      rx = b;
      wait_ticks(16);
   endtask

   task automatic send_frame(input logic [7:0] d, input bit par_en, input bit par_bit,
                             input bit stop_bit);
      put_bit(1'b0);
      for (int i = 0; i < 8; i++) put_bit(d[i]);
      if (par_en) put_bit(par_bit);
      put_bit(stop_bit);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_valid"}, valid, 0);
      check({tag, "_data"},  dout,  0);
      check({tag, "_perr"},  perr,  0);
      check({tag, "_ferr"},  ferr,  0);
      check({tag, "_ovr"},   ovr,   0);
      check({tag, "_busy"},  busy,  0);
   endtask

   int n0;
   logic [7:0] v7e;

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst = 1'b0;
      put_bit(1'b1);

      // T1: 8N1 0xA5
      n0 = got_n; valid_cyc = 0;
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
      put_bit(1'b1);
      check("t1_count", got_n - n0, 1);
      check("t1_data", got_data, 8'hA5);
      check("t1_perr", got_pe, 0);
      check("t1_ferr", got_fe, 0);
      check("t1_valid_cycles", valid_cyc, 1);

      // T2: 5-tick glitch is a false start
      n0 = got_n;
      @(negedge clk); rx = 1'b0;
      wait_ticks(5);
      @(negedge clk);
      check("t2_busy_during", busy, 1);
      rx = 1'b1;
      wait_ticks(20);
      @(negedge clk);
      check("t2_busy_after", busy, 0);
      check("t2_no_frame", got_n - n0, 0);
      check("t2_valid", valid, 0);
      put_bit(1'b1);

      // T3: even parity, 0x03
      pmode = 2'b01;
      send_frame(8'h03, 1'b1, 1'b1, 1'b1);
      put_bit(1'b1);
      check("t3_bad_data", got_data, 8'h03);
      check("t3_bad_perr", got_pe, 1);
      check("t3_bad_ferr", got_fe, 0);
      send_frame(8'h03, 1'b1, 1'b0, 1'b1);
      put_bit(1'b1);
      check("t3_good_data", got_data, 8'h03);
      check("t3_good_perr", got_pe, 0);
      pmode = 2'b00;

      // T4: low stop bit, then break held for 40 bit times
      n0 = got_n;
      send_frame(8'h55, 1'b0, 1'b0, 1'b0);
      busy_seen = 1'b0;
      wait_ticks(40 * 16);
      check("t4_count", got_n - n0, 1);
      check("t4_data", got_data, 8'h55);
      check("t4_ferr", got_fe, 1);
      check("t4_no_restart", busy_seen, 0);
      put_bit(1'b1);
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
      put_bit(1'b1);
      check("t4_recover_data", got_data, 8'h3C);
      check("t4_recover_ferr", got_fe, 0);

      // T5: overrun while host stalls
      @(posedge clk); #1 ready = 1'b0;
      ovr_cyc = 0;
      n0 = got_n;
      send_frame(8'h11, 1'b0, 1'b0, 1'b1);
      put_bit(1'b1);
      send_frame(8'h22, 1'b0, 1'b0, 1'b1);
      put_bit(1'b1);
      @(negedge clk);
      check("t5_valid_held", valid, 1);
      check("t5_data_held", dout, 8'h11);
      check("t5_ovr_pulse", ovr_cyc, 1);
      @(posedge clk); #1 ready = 1'b1;
      repeat (2) @(negedge clk);
      check("t5_accept_count", got_n - n0, 1);
      check("t5_accept_data", got_data, 8'h11);
      check("t5_valid_drop", valid, 0);

      // T6: reset during data bit 4 of 0x7E
      n0 = got_n;
      v7e = 8'h7E;
      put_bit(1'b0);
      for (int i = 0; i < 4; i++) put_bit(v7e[i]);
      @(negedge clk); rx = v7e[4];
      wait_ticks(8);
      @(negedge clk); rst = 1'b1;
      #1;
      check_outputs_zero("t6_reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      rx = 1'b1;
      wait_ticks(32);
      check("t6_no_frame", got_n - n0, 0);
      send_frame(8'h81, 1'b0, 1'b0, 1'b1);
      put_bit(1'b1);
      check("t6_count", got_n - n0, 1);
      check("t6_data", got_data, 8'h81);
      check("t6_ferr", got_fe, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
